// File: rtl/ram_noc_pkg.sv
// Shared types and helpers for the RAM-over-NoC masters: state encoding,
// the write-ack code, the test pattern and request/response (un)packing.
package ram_noc_pkg;

    localparam logic [7:0] ACK_DATA = 8'h80;
    localparam int CTRL_W  = 2;
    localparam int FIELD_W = 32;
    localparam int PACK_W  = 64;

    typedef enum logic [2:0] {IDLE, WR, WAIT_WR, RD, WAIT_RD, DONE} state_t;

    function automatic logic [FIELD_W-1:0] mask_w(input logic [FIELD_W-1:0] v, input int w);
        if (w >= FIELD_W) return v;
        return v & ((32'd1 << w) - 32'd1);
    endfunction

    // Expected data for a word: low data-width bits of its address XOR the seed.
    function automatic logic [FIELD_W-1:0] pattern(input logic [FIELD_W-1:0] addr,
                                                   input logic [FIELD_W-1:0] seed, input int w);
        return mask_w(mask_w(addr, w) ^ seed, w);
    endfunction

    function automatic logic [PACK_W-1:0] pack_req(input logic [FIELD_W-1:0] data,
                                                   input logic [FIELD_W-1:0] addr,
                                                   input logic we, input logic re,
                                                   input logic [FIELD_W-1:0] src,
                                                   input int aw, input int nw);
        return (64'(data) << (aw + CTRL_W + nw)) | (64'(addr) << (CTRL_W + nw)) |
               (64'(we) << (nw + 1)) | (64'(re) << nw) | 64'(src);
    endfunction

    function automatic logic [FIELD_W-1:0] resp_data(input logic [PACK_W-1:0] p, input int w, input int nw);
        logic [PACK_W-1:0] s;
        s = p >> nw;
        return mask_w(s[FIELD_W-1:0], w);
    endfunction

    function automatic logic [FIELD_W-1:0] resp_src(input logic [PACK_W-1:0] p, input int nw);
        return mask_w(p[FIELD_W-1:0], nw);
    endfunction

endpackage

// File: rtl/ram_credit_counter.sv
// Outstanding-request credit counter; saturates at CREDITS on unexpected returns.
module ram_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         take,
    input  logic                         give,
    output logic [$clog2(CREDITS+1)-1:0] count,
    output logic                         avail,
    output logic                         full,
    output logic                         overflow
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (take && !give)
            count_nxt = count - CW'(1);
        else if (give && !take && !full)
            count_nxt = count + CW'(1);
    end

    assign full     = (count == CW'(CREDITS));
    assign overflow = give & full;
    // Lookahead: a credit will be held at the start of next cycle.
    assign avail    = (count_nxt != '0);

    always_ff @(posedge clk) begin
        if (rst) count <= CW'(CREDITS);
        else     count <= count_nxt;
    end

endmodule

// File: rtl/ram_master.sv
// Credit-based RAM test master: writes a seeded pattern to its slice, reads it back, counts errors.
// Define RAM_MASTER_LOG_EN to log requests/responses in simulation.
module ram_master
    import ram_noc_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               ADDR_WIDTH   = 7,
    parameter int               N            = 16,
    parameter int               N_ADDR_WIDTH = $clog2(N),
    parameter int               NODE         = 0,
    parameter int               RAM_NODE     = 15,
    parameter int               WORDS        = 8,
    parameter int               CREDITS      = 4,
    parameter logic [WIDTH-1:0] SEED         = 8'h5A,
    parameter int               PACKED_OUT   = WIDTH + ADDR_WIDTH + 2 + N_ADDR_WIDTH,
    parameter int               PACKED_IN    = WIDTH + N_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [PACKED_OUT-1:0]        o_packed_out,
    output logic [N_ADDR_WIDTH-1:0]      o_dest_out,
    output logic                         o_valid_out,
    input  logic                         o_ready_in,
    input  logic [PACKED_IN-1:0]         i_packed_in,
    input  logic                         i_valid_in,
    output logic                         i_ready_out,
    output logic                         done,
    output logic                         pass,
    output logic [7:0]                   err_count,
    output logic [$clog2(CREDITS+1)-1:0] credits
);
    localparam int          IW   = $clog2(WORDS + 1);
    localparam logic [31:0] BASE = 32'(NODE * WORDS);

    state_t        state;
    logic [IW-1:0] iss_idx, chk_idx;
    logic          take, give, active, avail, full, overflow;
    logic [31:0]   rsp_data, rsp_src;
    logic          bad_src, bad_data;
    logic [7:0]    err_nxt;

    function automatic logic [31:0] word_addr(input logic [IW-1:0] k);
        return 32'(ADDR_WIDTH'(BASE + 32'(k)));
    endfunction

    function automatic logic [PACKED_OUT-1:0] build_req(input logic [IW-1:0] k, input logic wr);
        logic [31:0] addr;
        logic [63:0] p;
        addr = word_addr(k);
        p = pack_req(wr ? pattern(addr, 32'(SEED), WIDTH) : 32'd0, addr, wr, !wr,
                     32'(NODE), ADDR_WIDTH, N_ADDR_WIDTH);
        return p[PACKED_OUT-1:0];
    endfunction

    function automatic logic [7:0] sat_add_err(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign active      = (state == WR) || (state == WAIT_WR) || (state == RD) || (state == WAIT_RD);
    assign take        = o_valid_out & o_ready_in;
    assign give        = i_valid_in & active;
    assign i_ready_out = 1'b1;

    ram_credit_counter #(.CREDITS(CREDITS)) u_credits (
        .clk      (clk),
        .rst      (rst),
        .take     (take),
        .give     (give),
        .count    (credits),
        .avail    (avail),
        .full     (full),
        .overflow (overflow)
    );

    assign rsp_data = resp_data(64'(i_packed_in), WIDTH, N_ADDR_WIDTH);
    assign rsp_src  = resp_src(64'(i_packed_in), N_ADDR_WIDTH);

    always_comb begin
        bad_src  = (rsp_src != 32'(RAM_NODE));
        bad_data = 1'b0;
        if (state == WR || state == WAIT_WR)
            bad_data = (rsp_data != 32'(ACK_DATA));
        else
            bad_data = (rsp_data != pattern(word_addr(chk_idx), 32'(SEED), WIDTH));
        err_nxt = err_count;
        if (give)
            err_nxt = sat_add_err(err_count, {1'b0, bad_src} + {1'b0, bad_data} + {1'b0, overflow});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_valid_out  <= 1'b0;
            o_packed_out <= '0;
            o_dest_out   <= N_ADDR_WIDTH'(RAM_NODE);
            iss_idx      <= '0;
            chk_idx      <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
        end else begin
            err_count <= err_nxt;
            if (give && (state == RD || state == WAIT_RD))
                chk_idx <= chk_idx + IW'(1);
            case (state)
                IDLE, DONE: if (start) begin
                    state        <= WR;
                    o_valid_out  <= 1'b1;
                    o_packed_out <= build_req('0, 1'b1);
                    iss_idx      <= '0;
                    chk_idx      <= '0;
                    err_count    <= '0;
                    done         <= 1'b0;
                    pass         <= 1'b0;
                end
                WR, RD: begin
                    if (take && iss_idx == IW'(WORDS - 1)) begin
                        o_valid_out <= 1'b0;
                        iss_idx     <= '0;
                        state       <= (state == WR) ? WAIT_WR : WAIT_RD;
                    end else begin
                        if (take)
                            iss_idx <= iss_idx + IW'(1);
                        // Payload only moves when the current one was accepted or none is offered.
                        if (take || !o_valid_out) begin
                            o_valid_out  <= avail;
                            o_packed_out <= build_req(take ? iss_idx + IW'(1) : iss_idx, state == WR);
                        end
                    end
                end
                WAIT_WR: if (full) begin
                    state        <= RD;
                    o_valid_out  <= 1'b1;
                    o_packed_out <= build_req('0, 1'b0);
                end
                WAIT_RD: if (full) begin
                    state <= DONE;
                    done  <= 1'b1;
                    pass  <= (err_nxt == 8'd0);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_MASTER_LOG_EN
    always @(posedge clk) begin
        if (!rst && take)
            $display("master_%0d %0t req %s addr=%0h data=%0h", NODE, $time,
                     o_packed_out[N_ADDR_WIDTH+1] ? "WR" : "RD",
                     o_packed_out[N_ADDR_WIDTH+2 +: ADDR_WIDTH],
                     o_packed_out[PACKED_OUT-1 -: WIDTH]);
        if (!rst && give)
            $display("master_%0d %0t rsp data=%0h ok=%0d", NODE, $time, rsp_data,
                     !(bad_src || bad_data || overflow));
    end
`endif

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: loopback RAM model with variable latency, request scoreboard, scenario table.
module tb_ram_master;
    localparam int WIDTH = 8, ADDR_WIDTH = 7, N = 16, NAW = 4, NODE = 2, RAM_NODE = 15;
    localparam int WORDS = 8, CREDITS = 4, CW = 3;
    localparam int PO = WIDTH + ADDR_WIDTH + 2 + NAW;
    localparam int PI = WIDTH + NAW;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [PO-1:0]  o_packed_out;
    logic [NAW-1:0] o_dest_out;
    logic           o_valid_out, o_ready_in = 1'b0;
    logic [PI-1:0]  i_packed_in = '0;
    logic           i_valid_in = 1'b0, i_ready_out, done, pass;
    logic [7:0]     err_count;
    logic [CW-1:0]  credits;

    ram_master #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .N(N), .NODE(NODE), .RAM_NODE(RAM_NODE),
                 .WORDS(WORDS), .CREDITS(CREDITS), .SEED(8'h5A)) dut (
        .clk(clk), .rst(rst), .start(start),
        .o_packed_out(o_packed_out), .o_dest_out(o_dest_out), .o_valid_out(o_valid_out),
        .o_ready_in(o_ready_in), .i_packed_in(i_packed_in), .i_valid_in(i_valid_in),
        .i_ready_out(i_ready_out), .done(done), .pass(pass), .err_count(err_count), .credits(credits)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model and scoreboard state
    logic [WIDTH-1:0] mem [0:127];
    logic [PI-1:0]    pipe_d [0:7];
    logic             pipe_v [0:7];
    logic [PO-1:0]    exp_q [$];
    int lat, stall_after, stall_left, corrupt_addr, bad_ack, spur_en, spur_done;
    int n_wr, n_rd, n_rsp, outstanding, cred_err, hold_err, hold_obs, min_cred;
    bit track;
    logic prev_vld, prev_rdy;
    logic [PO-1:0] prev_pkt;

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
        stall_after = 0; stall_left = 0; corrupt_addr = -1; bad_ack = 0; spur_en = 0; spur_done = 0;
        n_wr = 0; n_rd = 0; n_rsp = 0; outstanding = 0; cred_err = 0; hold_err = 0; hold_obs = 0;
        min_cred = CREDITS; prev_vld = 1'b0; prev_rdy = 1'b1; prev_pkt = '0;
        exp_q.delete();
    endtask

    task automatic push_expected();
        logic [ADDR_WIDTH-1:0] a;
        logic [WIDTH-1:0] d;
        for (int k = 0; k < WORDS; k++) begin
            a = ADDR_WIDTH'(NODE * WORDS + k);
            d = {1'b0, a} ^ 8'h5A;
            exp_q.push_back({d, a, 1'b1, 1'b0, 4'(NODE)});
        end
        for (int k = 0; k < WORDS; k++) begin
            a = ADDR_WIDTH'(NODE * WORDS + k);
            exp_q.push_back({8'h00, a, 1'b0, 1'b1, 4'(NODE)});
        end
    endtask

    // Called at a negedge: observe, drive inputs for the next posedge, advance to next negedge.
    task automatic cycle();
        logic rdy, xfer, we, re;
        logic [WIDTH-1:0] d;
        logic [ADDR_WIDTH-1:0] a;
        logic [NAW-1:0] who;
        logic [PI-1:0] resp;
        logic [PO-1:0] exp_pkt;
        if (track) begin
            if (credits !== CW'(CREDITS - outstanding)) cred_err++;
            if (o_valid_out && credits == 0) cred_err++;
            if (outstanding > CREDITS) cred_err++;
            if (int'(credits) < min_cred) min_cred = int'(credits);
        end
        if (prev_vld && !prev_rdy) begin
            hold_obs++;
            if (!o_valid_out || o_packed_out !== prev_pkt) hold_err++;
        end
        rdy = 1'b1;
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
        o_ready_in = rdy;
        xfer = o_valid_out && rdy;
        i_valid_in  = pipe_v[0];
        i_packed_in = pipe_d[0];
        if (pipe_v[0]) begin outstanding--; n_rsp++; end
        for (int i = 0; i < 7; i++) begin pipe_v[i] = pipe_v[i+1]; pipe_d[i] = pipe_d[i+1]; end
        pipe_v[7] = 1'b0;
        if (spur_en != 0 && spur_done == 0 && !i_valid_in && n_wr == WORDS && n_rsp == WORDS &&
            n_rd == 0 && outstanding == 0 && credits == CW'(CREDITS) && !o_valid_out) begin
            i_valid_in  = 1'b1;
            i_packed_in = {8'h80, 4'(RAM_NODE)};
            spur_done   = 1;
        end
        if (xfer) begin
            if (exp_q.size() == 0) check("req_extra", 32'(o_packed_out), 32'hFFFF_FFFF);
            else begin
                exp_pkt = exp_q.pop_front();
                check("req_pkt", 32'(o_packed_out), 32'(exp_pkt));
            end
            {d, a, we, re, who} = o_packed_out;
            outstanding++;
            if (we) begin
                mem[a] = d;
                n_wr++;
                resp = {8'h80, (n_wr == bad_ack) ? 4'd14 : 4'(RAM_NODE)};
                if (n_wr == stall_after) stall_left = 5;
            end else begin
                n_rd++;
                resp = {mem[a] ^ ((int'(a) == corrupt_addr) ? 8'h01 : 8'h00), 4'(RAM_NODE)};
            end
            pipe_v[lat-1] = 1'b1;
            pipe_d[lat-1] = resp;
        end
        prev_vld = o_valid_out;
        prev_rdy = rdy;
        prev_pkt = o_packed_out;
        @(negedge clk);
    endtask

    typedef struct {
        int   lat;
        int   stall_at;
        int   corrupt;
        int   badack;
        int   spur;
        logic exp_pass;
        int   exp_err;
        int   exp_min;
        int   exp_hold;
    } vec_t;

    task automatic run(input vec_t v, input string tag);
        clear_model();
        lat = v.lat; stall_after = v.stall_at; corrupt_addr = v.corrupt;
        bad_ack = v.badack; spur_en = v.spur; track = 1'b1;
        push_expected();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check({tag, " first_req_valid"}, 32'(o_valid_out), 32'd1);
        for (int c = 0; c < 400 && !done; c++) cycle();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
        check({tag, " err_count"}, 32'(err_count), 32'(v.exp_err));
        check({tag, " req_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, " rsp_count"}, 32'(n_rsp), 32'(2 * WORDS));
        check({tag, " credit_track"}, 32'(cred_err), 32'd0);
        check({tag, " min_credits"}, 32'(min_cred), 32'(v.exp_min));
        check({tag, " hold_obs"}, 32'(hold_obs), 32'(v.exp_hold));
        check({tag, " hold_err"}, 32'(hold_err), 32'd0);
        check({tag, " spurious_sent"}, 32'(spur_done), 32'(v.spur));
    endtask

    initial begin
        vec_t vecs [7];
        int late_err, rsp_before;
        vecs[0] = '{lat:1, stall_at:0, corrupt:-1, badack:0, spur:0, exp_pass:1'b1, exp_err:0, exp_min:3, exp_hold:0};
        vecs[1] = '{lat:2, stall_at:0, corrupt:-1, badack:0, spur:0, exp_pass:1'b1, exp_err:0, exp_min:2, exp_hold:0};
        vecs[2] = '{lat:5, stall_at:0, corrupt:-1, badack:0, spur:0, exp_pass:1'b1, exp_err:0, exp_min:0, exp_hold:0};
        vecs[3] = '{lat:1, stall_at:3, corrupt:-1, badack:0, spur:0, exp_pass:1'b1, exp_err:0, exp_min:3, exp_hold:5};
        vecs[4] = '{lat:1, stall_at:0, corrupt:19, badack:0, spur:0, exp_pass:1'b0, exp_err:1, exp_min:3, exp_hold:0};
        vecs[5] = '{lat:1, stall_at:0, corrupt:19, badack:2, spur:0, exp_pass:1'b0, exp_err:2, exp_min:3, exp_hold:0};
        vecs[6] = '{lat:1, stall_at:0, corrupt:-1, badack:0, spur:1, exp_pass:1'b0, exp_err:1, exp_min:3, exp_hold:0};

        clear_model();
        lat = 1; track = 1'b0; rst = 1'b1;
        @(negedge clk);
        repeat (3) cycle();
        check("rst valid", 32'(o_valid_out), 32'd0);
        check("rst packed", 32'(o_packed_out), 32'd0);
        check("rst dest", 32'(o_dest_out), 32'(RAM_NODE));
        check("rst credits", 32'(credits), 32'(CREDITS));
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst err", 32'(err_count), 32'd0);
        check("ready_out", 32'(i_ready_out), 32'd1);
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("vec%0d", i));

        // Abort during the read phase with responses still in flight.
        clear_model();
        lat = 2; track = 1'b1;
        push_expected();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 200 && n_rd < 3; c++) cycle();
        check("abort reached_rd", 32'(n_rd >= 3), 32'd1);
        check("abort in_flight", 32'(outstanding > 0), 32'd1);
        track = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        stall_left = 1;
        rsp_before = n_rsp;
        cycle();
        rst = 1'b0;
        check("abort valid", 32'(o_valid_out), 32'd0);
        check("abort credits", 32'(credits), 32'(CREDITS));
        check("abort done", 32'(done), 32'd0);
        late_err = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (credits !== CW'(CREDITS) || o_valid_out !== 1'b0 || err_count !== 8'd0 || done !== 1'b0)
                late_err++;
        end
        check("abort late_rsp_seen", 32'(n_rsp > rsp_before + 1), 32'd1);
        check("abort late_ignored", 32'(late_err), 32'd0);
        run(vecs[0], "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
